logic_op_scheduler: RTL and testbench

- Shares one 32-bit bitwise logic datapath (AND/NAND/OR/NOR/XOR bitslices behind an op-select mux) between two requesters.
- Round-robin arbitrates requests and drives registered, stable operands and op-select onto the datapath.
- Waits a programmable number of cycles for the gate-delay datapath to settle.
- Captures the result, computes a zero flag, and returns it over a valid/ready response channel.

---
 rtl/logic_op_scheduler_pkg.sv | 30 +++
 rtl/logic_op_scheduler_if.sv | 76 +++++++
 rtl/logic_op_scheduler_arb.sv | 26 ++
 rtl/logic_op_scheduler.sv | 176 +++++++++++++++++
 tb/tb_logic_op_scheduler.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/logic_op_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// logic_sched_pkg
// Shared constants and types for the logic-op scheduler: opcode encoding,
// FSM state encoding, settle-counter width and an opcode legality helper.
// Optional feature macro used elsewhere in this slice: LOGIC_SCHED_ERR_EN.
// -----------------------------------------------------------------------------
package logic_sched_pkg;

    localparam int CNT_W = 4;   // settle counter width (SETTLE_CYCLES <= 15)
    localparam int OP_W  = 3;   // opcode width

    localparam logic [OP_W-1:0] OP_AND         = 3'd0;
    localparam logic [OP_W-1:0] OP_NAND        = 3'd1;
    localparam logic [OP_W-1:0] OP_OR          = 3'd2;
    localparam logic [OP_W-1:0] OP_NOR         = 3'd3;
    localparam logic [OP_W-1:0] OP_XOR         = 3'd4;
    localparam logic [OP_W-1:0] OP_ILLEGAL_MIN = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Opcodes 5..7 have no bitslice behind the datapath mux.
    function automatic logic op_is_illegal(input logic [OP_W-1:0] op);
        return (op >= OP_ILLEGAL_MIN);
    endfunction

endpackage

// File: rtl/logic_op_scheduler_if.sv
// -----------------------------------------------------------------------------
// logic_sched_if
// Bundles the two request channels, the datapath drive/return bus and the
// response channel of the logic-op scheduler.
//   slave  : scheduler side (accepts requests, drives datapath and response)
//   master : requester / datapath / consumer side
// Signals:
//   reqX_valid/ready/op/a/b : requester X command channel (X = 0,1)
//   dp_sel/dp_a/dp_b        : registered op-select and operands to datapath
//   dp_result               : datapath output
//   rsp_valid/ready/id/result/zero : response channel
//   rsp_err/err_seen        : only when LOGIC_SCHED_ERR_EN is defined
// -----------------------------------------------------------------------------
interface logic_sched_if
    import logic_sched_pkg::*;
#(
    parameter int N = 31
);
    logic            req0_valid;
    logic            req0_ready;
    logic [OP_W-1:0] req0_op;
    logic [N:0]      req0_a;
    logic [N:0]      req0_b;

    logic            req1_valid;
    logic            req1_ready;
    logic [OP_W-1:0] req1_op;
    logic [N:0]      req1_a;
    logic [N:0]      req1_b;

    logic [OP_W-1:0] dp_sel;
    logic [N:0]      dp_a;
    logic [N:0]      dp_b;
    logic [N:0]      dp_result;

    logic            rsp_valid;
    logic            rsp_ready;
    logic            rsp_id;
    logic [N:0]      rsp_result;
    logic            rsp_zero;
`ifdef LOGIC_SCHED_ERR_EN
    logic            rsp_err;
    logic            err_seen;
`endif

    modport slave (
`ifdef LOGIC_SCHED_ERR_EN
        output rsp_err,
        output err_seen,
`endif
        input  req0_valid, req0_op, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_op, req1_a, req1_b,
        output req1_ready,
        output dp_sel, dp_a, dp_b,
        input  dp_result,
        output rsp_valid, rsp_id, rsp_result, rsp_zero,
        input  rsp_ready
    );

    modport master (
`ifdef LOGIC_SCHED_ERR_EN
        input  rsp_err,
        input  err_seen,
`endif
        output req0_valid, req0_op, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_op, req1_a, req1_b,
        input  req1_ready,
        input  dp_sel, dp_a, dp_b,
        output dp_result,
        input  rsp_valid, rsp_id, rsp_result, rsp_zero,
        output rsp_ready
    );

endinterface

// File: rtl/logic_op_scheduler_arb.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter. Purely combinational; the caller owns the
// last_grant register and updates it on an accepted grant.
// Ports:
//   i_req[1:0]     : request lines
//   i_last_grant   : requester granted most recently
//   i_enable       : arbitration allowed this cycle
//   o_grant_valid  : a grant is issued
//   o_grant_id     : granted requester
// -----------------------------------------------------------------------------
module rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_last_grant,
    input  logic       i_enable,
    output logic       o_grant_valid,
    output logic       o_grant_id
);

    assign o_grant_valid = i_enable && (|i_req);

    // On a tie the requester not served last wins; otherwise the lone
    // requester wins (req[1] alone -> 1, req[0] alone -> 0).
    assign o_grant_id = (&i_req) ? ~i_last_grant : i_req[1];

endmodule

// File: rtl/logic_op_scheduler.sv
// -----------------------------------------------------------------------------
// logic_op_scheduler
// Shares one external (n+1)-bit bitwise logic datapath between two
// requesters. Round-robin arbitrates, drives registered operands/op-select
// onto the datapath, waits SETTLE_CYCLES for the gate-delay path to settle,
// then captures the result with a zero flag and returns it on a
// valid/ready response channel.
// Parameters:
//   n             : operand MSB index (datapath width n+1)
//   SETTLE_CYCLES : cycles operands are held before capture, 1..15
// Ports:
//   i_clk   : clock, rising edge
//   i_reset : asynchronous active-high reset
//   io_bus  : logic_sched_if.slave (request, datapath and response channels)
// Optional feature macro: LOGIC_SCHED_ERR_EN adds rsp_err (per response,
// set for opcodes 5..7) and sticky err_seen (cleared only by reset).
// -----------------------------------------------------------------------------
module logic_op_scheduler
    import logic_sched_pkg::*;
#(
    parameter int n             = 31,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic          i_clk,
    input  logic          i_reset,
    logic_sched_if.slave  io_bus
);

    generate
        if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
            $error("logic_op_scheduler: SETTLE_CYCLES must be in 1..15");
        end
    endgenerate

    localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic            r_last_grant;

    logic [OP_W-1:0] r_dp_sel;
    logic [n:0]      r_dp_a;
    logic [n:0]      r_dp_b;

    logic            r_rsp_valid;
    logic            r_rsp_id;
    logic [n:0]      r_rsp_result;
    logic            r_rsp_zero;

    logic            w_grant_valid;
    logic            w_grant_id;
    logic            w_accept;
    logic            w_capture;
    logic            w_rsp_hs;
    logic            w_illegal;
    logic [OP_W-1:0] w_op;
    logic [n:0]      w_a;
    logic [n:0]      w_b;
    logic [n:0]      w_cap_val;

    // ---------------------------------------------------------------- arbiter
    rr_arb2 u_arb (
        .i_req         ({io_bus.req1_valid, io_bus.req0_valid}),
        .i_last_grant  (r_last_grant),
        .i_enable      (r_state == ST_IDLE),
        .o_grant_valid (w_grant_valid),
        .o_grant_id    (w_grant_id)
    );

    // A grant already implies the chosen requester is valid, so the grant
    // itself is the handshake.
    assign w_accept          = w_grant_valid;
    assign io_bus.req0_ready = w_grant_valid && !w_grant_id;
    assign io_bus.req1_ready = w_grant_valid &&  w_grant_id;

    assign w_op = w_grant_id ? io_bus.req1_op : io_bus.req0_op;
    assign w_a  = w_grant_id ? io_bus.req1_a  : io_bus.req0_a;
    assign w_b  = w_grant_id ? io_bus.req1_b  : io_bus.req0_b;

    // ---------------------------------------------------------- capture logic
    assign w_capture = (r_state == ST_SETTLE) && (r_cnt == CNT_ONE);
    assign w_rsp_hs  = r_rsp_valid && io_bus.rsp_ready;
    assign w_illegal = op_is_illegal(r_dp_sel);
    // The mux output for opcodes 5..7 is undefined, so it is never sampled.
    assign w_cap_val = w_illegal ? '0 : io_bus.dp_result;

    // -------------------------------------------------------------------- FSM
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:   if (w_accept)  w_state_nxt = ST_SETTLE;
            ST_SETTLE: if (w_capture) w_state_nxt = ST_RESP;
            ST_RESP:   if (w_rsp_hs)  w_state_nxt = ST_IDLE;
            default:                  w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------- arbitration / settle counter
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_last_grant <= 1'b1;   // so requester 0 wins the first tie
            r_cnt        <= '0;
        end else if (w_accept) begin
            r_last_grant <= w_grant_id;
            r_cnt        <= SETTLE_INIT;
        end else if (r_state == ST_SETTLE) begin
            r_cnt        <= r_cnt - CNT_ONE;
        end
    end

    // ---------------------------------------------------- datapath drive regs
    // Held from acceptance until the next acceptance; not cleared in IDLE.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_dp_sel <= '0;
            r_dp_a   <= '0;
            r_dp_b   <= '0;
            r_rsp_id <= 1'b0;
        end else if (w_accept) begin
            r_dp_sel <= w_op;
            r_dp_a   <= w_a;
            r_dp_b   <= w_b;
            r_rsp_id <= w_grant_id;
        end
    end

    // ---------------------------------------------------------- response regs
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_zero   <= 1'b0;
        end else if (w_capture) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_result <= w_cap_val;
            r_rsp_zero   <= (w_cap_val == '0);
        end else if (w_rsp_hs) begin
            r_rsp_valid  <= 1'b0;
        end
    end

`ifdef LOGIC_SCHED_ERR_EN
    logic r_rsp_err;
    logic r_err_seen;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rsp_err  <= 1'b0;
            r_err_seen <= 1'b0;
        end else if (w_capture) begin
            r_rsp_err  <= w_illegal;
            r_err_seen <= r_err_seen | w_illegal;
        end
    end

    assign io_bus.rsp_err  = r_rsp_err;
    assign io_bus.err_seen = r_err_seen;
`endif

    // ---------------------------------------------------------------- outputs
    assign io_bus.dp_sel     = r_dp_sel;
    assign io_bus.dp_a       = r_dp_a;
    assign io_bus.dp_b       = r_dp_b;
    assign io_bus.rsp_valid  = r_rsp_valid;
    assign io_bus.rsp_id     = r_rsp_id;
    assign io_bus.rsp_result = r_rsp_result;
    assign io_bus.rsp_zero   = r_rsp_zero;

endmodule

// File: tb/tb_logic_op_scheduler.sv
// -----------------------------------------------------------------------------
// tb_logic_op_scheduler
// Drives two scheduler instances (SETTLE_CYCLES=2 and =1) through a table of
// single-requester ops plus hand sequences for fairness, backpressure, reset
// in flight and the short-settle build. Each instance sees a behavioural
// bitslice datapath behind a dp_sel mux; expected responses for the main
// instance go through a scoreboard queue popped on every response handshake.
// -----------------------------------------------------------------------------
module tb_logic_op_scheduler;
    import logic_sched_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    always #50 clk = ~clk;

    logic_sched_if #(.N(W-1)) bus  ();
    logic_sched_if #(.N(W-1)) bus1 ();

    logic_op_scheduler #(.n(W-1), .SETTLE_CYCLES(2)) dut (
        .i_clk (clk), .i_reset (rst), .io_bus (bus)
    );
    logic_op_scheduler #(.n(W-1), .SETTLE_CYCLES(1)) dut1 (
        .i_clk (clk), .i_reset (rst), .io_bus (bus1)
    );

    // ------------------------------------------------ datapath bitslices + mux
    logic [W-1:0] s_and, s_nand, s_or, s_nor, s_xor;
    assign s_and  = bus.dp_a & bus.dp_b;
    assign s_nand = ~(bus.dp_a & bus.dp_b);
    assign s_or   = bus.dp_a | bus.dp_b;
    assign s_nor  = ~(bus.dp_a | bus.dp_b);
    assign s_xor  = bus.dp_a ^ bus.dp_b;

    always_comb begin
        bus.dp_result = 32'hDEAD_BEEF;   // undriven mux leg for opcodes 5..7
        case (bus.dp_sel)
            3'd0: bus.dp_result = s_and;
            3'd1: bus.dp_result = s_nand;
            3'd2: bus.dp_result = s_or;
            3'd3: bus.dp_result = s_nor;
            3'd4: bus.dp_result = s_xor;
            default: ;
        endcase
    end

    function automatic logic [W-1:0] dp_fn(input logic [2:0] s, input logic [W-1:0] a, b);
        case (s)
            3'd0:    return a & b;
            3'd1:    return ~(a & b);
            3'd2:    return a | b;
            3'd3:    return ~(a | b);
            3'd4:    return a ^ b;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction
    assign bus1.dp_result = dp_fn(bus1.dp_sel, bus1.dp_a, bus1.dp_b);

    // ------------------------------------------------------------- scoreboard
    typedef struct {
        logic         id;
        logic [W-1:0] res;
        logic         zero;
        logic         err;
    } exp_t;

    typedef struct {
        logic         id;
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         zero;
        logic         err;
    } vec_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic exp_t mk_exp(input logic id, input logic [W-1:0] res,
                                    input logic zero, input logic err);
        exp_t e;
        e.id = id; e.res = res; e.zero = zero; e.err = err;
        return e;
    endfunction

    function automatic vec_t mk_vec(input logic id, input logic [2:0] op,
                                    input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic [W-1:0] res, input logic zero,
                                    input logic err);
        vec_t v;
        v.id = id; v.op = op; v.a = a; v.b = b;
        v.res = res; v.zero = zero; v.err = err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    // Response monitor: a handshake seen at the negedge completes at the next
    // posedge, so the front scoreboard entry is checked here.
    always @(negedge clk) begin
        exp_t e;
        if (bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_rsp: got id %0d result 0x%h, expected no response",
                         bus.rsp_id, bus.rsp_result);
            end else begin
                e = sb.pop_front();
                chk("rsp_id",     W'(bus.rsp_id),   W'(e.id));
                chk("rsp_result", bus.rsp_result,   e.res);
                chk("rsp_zero",   W'(bus.rsp_zero), W'(e.zero));
`ifdef LOGIC_SCHED_ERR_EN
                chk("rsp_err",    W'(bus.rsp_err),  W'(e.err));
`endif
            end
        end
    end

    // --------------------------------------------------------------- helpers
    task automatic drive_req(input logic id, input logic v, input logic [2:0] op,
                             input logic [W-1:0] a, input logic [W-1:0] b);
        if (!id) begin
            bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
        end else begin
            bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
        end
    endtask

    // Raise valid, wait for ready, return just after the accepting edge.
    task automatic send(input logic id, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit do_push, input exp_t e);
        logic got;
        got = 1'b0;
        drive_req(id, 1'b1, op, a, b);
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = id ? bus.req1_ready : bus.req0_ready;
        end
        chk("accept", W'(got), 32'd1);
        if (got && do_push) sb.push_back(e);
        @(posedge clk); #1;
        drive_req(id, 1'b0, op, a, b);
    endtask

    // Count negedges until the response handshake is seen.
    task automatic wait_rsp(output int lat);
        logic seen;
        seen = 1'b0;
        lat  = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            lat++;
            seen = bus.rsp_valid && bus.rsp_ready;
        end
        chk("rsp_timeout", W'(seen), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #(100 * 20000);
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------- test
    initial begin
        vec_t       vecs[12];
        int         lat;
        int         ng;
        logic [3:0] order;
        logic       seen;
        logic       any_rsp;

        vecs[0]  = mk_vec(0, OP_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 0, 0);
        vecs[1]  = mk_vec(1, OP_NAND, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0);
        vecs[2]  = mk_vec(0, OP_OR,   32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 0, 0);
        vecs[3]  = mk_vec(1, OP_NOR,  32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 0, 0);
        vecs[4]  = mk_vec(0, OP_XOR,  32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'h0000_0000, 1, 0);
        vecs[5]  = mk_vec(1, OP_XOR,  32'h1234_5678, 32'hFFFF_FFFF, 32'hEDCB_A987, 0, 0);
        vecs[6]  = mk_vec(0, 3'd6,    32'h1234_5678, 32'hFFFF_FFFF, 32'h0000_0000, 1, 1);
        vecs[7]  = mk_vec(1, OP_NAND, 32'h0F0F_0F0F, 32'h00FF_00FF, 32'hFFF0_FFF0, 0, 0);
        vecs[8]  = mk_vec(0, OP_NOR,  32'hFFFF_0000, 32'h0000_FFFF, 32'h0000_0000, 1, 0);
        vecs[9]  = mk_vec(1, 3'd5,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1, 1);
        vecs[10] = mk_vec(0, 3'd7,    32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1, 1);
        vecs[11] = mk_vec(1, OP_AND,  32'h8000_0001, 32'h8000_0000, 32'h8000_0000, 0, 0);

        rst = 1'b1;
        drive_req(0, 0, 3'd0, '0, '0);
        drive_req(1, 0, 3'd0, '0, '0);
        bus.rsp_ready   = 1'b1;
        bus1.req0_valid = 0; bus1.req0_op = '0; bus1.req0_a = '0; bus1.req0_b = '0;
        bus1.req1_valid = 0; bus1.req1_op = '0; bus1.req1_a = '0; bus1.req1_b = '0;
        bus1.rsp_ready  = 1'b1;

        // reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rsp_valid",  W'(bus.rsp_valid), 32'd0);
        chk("rst_dp_sel",     W'(bus.dp_sel),    32'd0);
        chk("rst_dp_a",       bus.dp_a,          32'd0);
        chk("rst_dp_b",       bus.dp_b,          32'd0);
        chk("rst_rsp_result", bus.rsp_result,    32'd0);
        chk("rst_rsp_zero",   W'(bus.rsp_zero),  32'd0);
        chk("rst_rsp_id",     W'(bus.rsp_id),    32'd0);
`ifdef LOGIC_SCHED_ERR_EN
        chk("rst_rsp_err",    W'(bus.rsp_err),   32'd0);
        chk("rst_err_seen",   W'(bus.err_seen),  32'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // fairness: both requesters held valid across four grants
        drive_req(0, 1, OP_XOR, 32'hAAAA_AAAA, 32'hAAAA_AAAA);
        drive_req(1, 1, OP_OR,  32'h0000_0001, 32'h0000_0002);
        ng    = 0;
        order = '0;
        for (int i = 0; i < 200 && ng < 4; i++) begin
            @(negedge clk);
            if (bus.req0_ready || bus.req1_ready) begin
                chk("one_ready", W'(bus.req0_ready & bus.req1_ready), 32'd0);
                order[ng] = bus.req1_ready;
                sb.push_back(bus.req1_ready ? mk_exp(1, 32'h3, 0, 0) : mk_exp(0, 32'h0, 1, 0));
                ng++;
            end
        end
        @(posedge clk); #1;
        drive_req(0, 0, OP_XOR, '0, '0);
        drive_req(1, 0, OP_OR,  '0, '0);
        chk("rr_grants", W'(ng),    32'd4);
        chk("rr_order",  W'(order), 32'b1010);
        wait_rsp(lat);

        // single op with latency
        send(0, OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 1, mk_exp(0, 32'hF000_F000, 0, 0));
        wait_rsp(lat);
        chk("latency_s2",   W'(lat),        32'd3);
        chk("dp_sel_held",  W'(bus.dp_sel), 32'd0);
        chk("dp_a_held",    bus.dp_a,       32'hF0F0_F0F0);

        // table
        for (int i = 0; i < 12; i++) begin
            send(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b, 1,
                 mk_exp(vecs[i].id, vecs[i].res, vecs[i].zero, vecs[i].err));
            wait_rsp(lat);
        end
`ifdef LOGIC_SCHED_ERR_EN
        chk("err_seen_sticky", W'(bus.err_seen), 32'd1);
`endif

        // reset while in SETTLE drops the command
        send(1, OP_NOR, 32'h0, 32'h0, 0, mk_exp(0, '0, 0, 0));
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid",  W'(bus.rsp_valid), 32'd0);
        chk("mid_rst_result", bus.rsp_result,    32'd0);
        chk("mid_rst_id",     W'(bus.rsp_id),    32'd0);
        chk("mid_rst_dp_sel", W'(bus.dp_sel),    32'd0);
`ifdef LOGIC_SCHED_ERR_EN
        chk("mid_rst_err_seen", W'(bus.err_seen), 32'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        any_rsp = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            any_rsp = any_rsp | bus.rsp_valid;
        end
        chk("no_rsp_after_rst", W'(any_rsp), 32'd0);
        @(posedge clk); #1;
        drive_req(0, 1, OP_AND, 32'hFFFF_0000, 32'h0F0F_0F0F);
        drive_req(1, 1, OP_OR,  32'h0000_0010, 32'h0000_0020);
        @(negedge clk);
        chk("tie_req0_ready", W'(bus.req0_ready), 32'd1);
        chk("tie_req1_ready", W'(bus.req1_ready), 32'd0);
        if (bus.req0_ready) sb.push_back(mk_exp(0, 32'h0F0F_0000, 0, 0));
        @(posedge clk); #1;
        drive_req(0, 0, OP_AND, '0, '0);
        drive_req(1, 0, OP_OR,  '0, '0);
        wait_rsp(lat);

        // backpressure: response held, requester 1 kept waiting
        bus.rsp_ready = 1'b0;
        send(0, OP_XOR, 32'h0F0F_0000, 32'h00FF_0000, 1, mk_exp(0, 32'h0FF0_0000, 0, 0));
        drive_req(1, 1, OP_OR, 32'h0, 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            seen = bus.rsp_valid;
        end
        chk("bp_rsp_valid_rise", W'(seen), 32'd1);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("bp_valid",      W'(bus.rsp_valid),  32'd1);
            chk("bp_result",     bus.rsp_result,     32'h0FF0_0000);
            chk("bp_id",         W'(bus.rsp_id),     32'd0);
            chk("bp_zero",       W'(bus.rsp_zero),   32'd0);
            chk("bp_req1_ready", W'(bus.req1_ready), 32'd0);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_done_valid",  W'(bus.rsp_valid),  32'd0);
        chk("bp_req1_accept", W'(bus.req1_ready), 32'd1);
        if (bus.req1_ready) sb.push_back(mk_exp(1, 32'h0, 1, 0));
        @(posedge clk); #1;
        drive_req(1, 0, OP_OR, '0, '0);
        wait_rsp(lat);

        // SETTLE_CYCLES=1 instance
        bus1.req0_op = OP_NAND; bus1.req0_a = 32'hFFFF_FFFF; bus1.req0_b = 32'hFFFF_FFFF;
        bus1.req0_valid = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = bus1.req0_ready;
        end
        chk("s1_accept", W'(seen), 32'd1);
        @(posedge clk); #1;
        bus1.req0_valid = 1'b0;
        seen = 1'b0;
        lat  = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            lat++;
            seen = bus1.rsp_valid;
        end
        chk("s1_latency", W'(lat),            32'd2);
        chk("s1_result",  bus1.rsp_result,    32'h0);
        chk("s1_zero",    W'(bus1.rsp_zero),  32'd1);
        chk("s1_id",      W'(bus1.rsp_id),    32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("s1_rsp_cleared", W'(bus1.rsp_valid), 32'd0);

        repeat (2) @(posedge clk);
        chk("sb_empty", W'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
